tmr_fault_monitor: RTL
======================

Name: tmr_fault_monitor

Overview:
- Downstream consumer of the three redundant RS5 result lanes (A/B/C) and the single point where their divergence is observed.
- Performs word-level majority voting and tracks per-lane consecutive-mismatch history; a persistently wrong lane is retired.
- Degrades from TMR to duplex to simplex as lanes are retired, and exposes registered voted data, error pulses and saturating statistics counters to the SoC/debug logic.

Parameters:
- WIDTH, 32, bit width of each result lane and of the voted output
- THRESHOLD, 3, consecutive mismatches (1..15) that retire a lane
- CNT_WIDTH, 16, width of the saturating statistics counters

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- valid_i  in  1  lanes carry a new result this cycle
- result_a_i  in  WIDTH  lane A result
- result_b_i  in  WIDTH  lane B result
- result_c_i  in  WIDTH  lane C result
- clear_faults_i  in  1  single-cycle pulse: return all lanes to OK, zero consecutive counters
- voted_o  out  WIDTH  voted result (registered)
- voted_valid_o  out  1  voted_o updated this cycle
- uncorrectable_o  out  1  pulse: sample had no agreeing pair among healthy lanes
- lane_faulty_o  out  3  bit0=A, bit1=B, bit2=C; lane in FAULTY state
- degraded_o  out  1  one or more lanes FAULTY
- mismatch_cnt_a_o / _b_o / _c_o  out  CNT_WIDTH each  total mismatches per lane, saturating
- uncorrectable_cnt_o  out  CNT_WIDTH  total uncorrectable samples, saturating

Behaviour:
- Reset (async, reset_n=0): voted_o=0, voted_valid_o=0, uncorrectable_o=0, lane_faulty_o=0, degraded_o=0, all counters 0, all lanes OK. Release takes effect on the next clk edge.
- Latency: all outputs are registered. A sample presented with valid_i at edge N appears at edge N+1. Full throughput (one sample per cycle); no backpressure.
- Cycles with valid_i=0: voted_valid_o=0, uncorrectable_o=0, voted_o holds, no state changes.
- Per-lane FSM (3 instances, each with a 4-bit consecutive counter cc):
  - OK: cc=0. A mismatch moves to SUSPECT with cc=1, or directly to FAULTY if THRESHOLD=1.
  - SUSPECT: a match returns to OK with cc=0. A mismatch increments cc; when cc reaches THRESHOLD, move to FAULTY.
  - FAULTY: sticky. The lane is excluded from voting and its counters freeze. Exits only on clear_faults_i or reset.
- Vote, 0 faulty lanes:
  - A==B or A==C: voted=A. Otherwise B==C: voted=B. Otherwise uncorrectable.
  - When a majority exists, each lane differing from voted records a mismatch and the others record a match.
- Vote, 1 faulty lane: the two healthy lanes are compared. If equal, voted = their value and both record a match. If different, the sample is uncorrectable.
- Vote, 2 faulty lanes: voted = remaining lane, never uncorrectable, no mismatch bookkeeping.
- Uncorrectable sample:
  - uncorrectable_o=1 and voted_valid_o=1; voted_o holds its previous value.
  - uncorrectable_cnt increments.
  - Lane FSMs and per-lane counters are unchanged, since no lane can be blamed.
- Three faulty lanes is unreachable by construction (simplex mode records no mismatches).
- mismatch_cnt_x increments on each mismatch recorded for lane x and saturates at 2^CNT_WIDTH-1. It is not reset by clear_faults_i; only reset_n clears it.
- degraded_o = OR of lane_faulty_o (registered).
- clear_faults_i together with valid_i in the same cycle: clear has priority. That sample is voted as if all lanes are OK, and its match/mismatch results are applied on top of the cleared state (a mismatch yields SUSPECT, cc=1).
- Reset asserted mid-stream: the in-flight sample is discarded and the next sample after release is voted in full TMR.

Test Plan:
- Reset, then valid_i with A=B=C=0x12345678 -> next cycle: voted_o=0x12345678, voted_valid_o=1, uncorrectable_o=0, all counters 0.
- A=B=0xAAAA0000, C=0xAAAA0001 for one sample, then all equal -> voted_o=0xAAAA0000, mismatch_cnt_c_o=1, lane C back to OK, lane_faulty_o=000.
- C wrong for 3 consecutive samples (THRESHOLD=3) -> lane_faulty_o=100 and degraded_o=1 after the third. A 4th sample with C wrong leaves mismatch_cnt_c_o=3 (frozen).
- With C faulty, A=0x1, B=0x2 -> uncorrectable_o=1, voted_o holds the prior value, uncorrectable_cnt_o=1.
- A=1, B=2, C=3 in full TMR -> uncorrectable pulse; lane FSMs and per-lane counters unchanged.
- Same cycle: clear_faults_i=1, valid_i=1, C wrong -> lane_faulty_o=000 next cycle, lane C in SUSPECT with cc=1. Also force mismatch_cnt_a to 0xFFFE, apply 3 A-mismatches -> counter reads 0xFFFF.

Source files
------------

// File: rtl/tmr_fault_monitor.sv
// Word-level TMR voter with per-lane consecutive-mismatch tracking, lane retirement
// (TMR -> duplex -> simplex) and saturating statistics counters.
module tmr_fault_monitor #(
  parameter int WIDTH     = 32,
  parameter int THRESHOLD = 3,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 valid_i,
  input  logic [WIDTH-1:0]     result_a_i,
  input  logic [WIDTH-1:0]     result_b_i,
  input  logic [WIDTH-1:0]     result_c_i,
  input  logic                 clear_faults_i,
  output logic [WIDTH-1:0]     voted_o,
  output logic                 voted_valid_o,
  output logic                 uncorrectable_o,
  output logic [2:0]           lane_faulty_o,
  output logic                 degraded_o,
  output logic [CNT_WIDTH-1:0] mismatch_cnt_a_o,
  output logic [CNT_WIDTH-1:0] mismatch_cnt_b_o,
  output logic [CNT_WIDTH-1:0] mismatch_cnt_c_o,
  output logic [CNT_WIDTH-1:0] uncorrectable_cnt_o
);

  typedef enum logic [1:0] {
    LANE_OK      = 2'd0,
    LANE_SUSPECT = 2'd1,
    LANE_FAULTY  = 2'd2
  } lane_state_t;

  localparam logic [3:0]           LP_THRESH  = 4'(THRESHOLD);
  localparam logic [CNT_WIDTH-1:0] LP_CNT_ONE = CNT_WIDTH'(1);

  lane_state_t          r_state     [3];
  lane_state_t          w_state_nxt [3];
  logic [3:0]           r_cc        [3];
  logic [3:0]           w_cc_nxt    [3];
  logic [CNT_WIDTH-1:0] r_mis_cnt   [3];
  logic [WIDTH-1:0]     w_res       [3];

  logic [WIDTH-1:0]     r_voted;
  logic                 r_voted_valid;
  logic                 r_uncorr;
  logic [2:0]           r_lane_faulty;
  logic                 r_degraded;
  logic [CNT_WIDTH-1:0] r_unc_cnt;

  logic [2:0]           w_healthy;
  logic [WIDTH-1:0]     w_vote;
  logic                 w_vote_ok;
  logic                 w_uncorr;
  logic                 w_blame;
  logic [2:0]           w_mis;
  logic [2:0]           w_mis_inc;
  logic [2:0]           w_faulty_nxt;

  // Healthy set is taken after a same-cycle clear, so that sample votes in full TMR.
  always_comb begin
    w_res[0]  = result_a_i;
    w_res[1]  = result_b_i;
    w_res[2]  = result_c_i;
    w_vote    = r_voted;
    w_vote_ok = 1'b0;
    w_uncorr  = 1'b0;
    w_blame   = 1'b0;
    w_mis     = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      w_healthy[i] = clear_faults_i || (r_state[i] != LANE_FAULTY);
    end
    case (w_healthy)
      3'b111: begin
        if ((result_a_i == result_b_i) || (result_a_i == result_c_i)) begin
          w_vote = result_a_i; w_vote_ok = 1'b1; w_blame = 1'b1;
        end else if (result_b_i == result_c_i) begin
          w_vote = result_b_i; w_vote_ok = 1'b1; w_blame = 1'b1;
        end else begin
          w_uncorr = 1'b1;
        end
      end
      3'b011: begin
        if (result_a_i == result_b_i) begin
          w_vote = result_a_i; w_vote_ok = 1'b1; w_blame = 1'b1;
        end else begin
          w_uncorr = 1'b1;
        end
      end
      3'b101: begin
        if (result_a_i == result_c_i) begin
          w_vote = result_a_i; w_vote_ok = 1'b1; w_blame = 1'b1;
        end else begin
          w_uncorr = 1'b1;
        end
      end
      3'b110: begin
        if (result_b_i == result_c_i) begin
          w_vote = result_b_i; w_vote_ok = 1'b1; w_blame = 1'b1;
        end else begin
          w_uncorr = 1'b1;
        end
      end
      3'b001: begin w_vote = result_a_i; w_vote_ok = 1'b1; end
      3'b010: begin w_vote = result_b_i; w_vote_ok = 1'b1; end
      3'b100: begin w_vote = result_c_i; w_vote_ok = 1'b1; end
      default: ;
    endcase
    if (w_blame) begin
      for (int unsigned i = 0; i < 3; i++) begin
        w_mis[i] = w_healthy[i] && (w_res[i] != w_vote);
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cc_nxt[i]    = r_cc[i];
      w_mis_inc[i]   = 1'b0;
      if (clear_faults_i) begin
        w_state_nxt[i] = LANE_OK;
        w_cc_nxt[i]    = '0;
      end
      if (valid_i && w_blame && w_healthy[i]) begin
        if (w_mis[i]) begin
          w_mis_inc[i]   = 1'b1;
          w_cc_nxt[i]    = w_cc_nxt[i] + 4'd1;
          w_state_nxt[i] = (w_cc_nxt[i] >= LP_THRESH) ? LANE_FAULTY : LANE_SUSPECT;
        end else begin
          w_state_nxt[i] = LANE_OK;
          w_cc_nxt[i]    = '0;
        end
      end
      w_faulty_nxt[i] = (w_state_nxt[i] == LANE_FAULTY);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 3; i++) begin
        r_state[i]   <= LANE_OK;
        r_cc[i]      <= '0;
        r_mis_cnt[i] <= '0;
      end
      r_voted       <= '0;
      r_voted_valid <= 1'b0;
      r_uncorr      <= 1'b0;
      r_lane_faulty <= '0;
      r_degraded    <= 1'b0;
      r_unc_cnt     <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cc[i]    <= w_cc_nxt[i];
        if (w_mis_inc[i] && (r_mis_cnt[i] != '1)) begin
          r_mis_cnt[i] <= r_mis_cnt[i] + LP_CNT_ONE;
        end
      end
      r_voted_valid <= valid_i;
      r_uncorr      <= valid_i && w_uncorr;
      if (valid_i && w_vote_ok) begin
        r_voted <= w_vote;
      end
      if (valid_i && w_uncorr && (r_unc_cnt != '1)) begin
        r_unc_cnt <= r_unc_cnt + LP_CNT_ONE;
      end
      r_lane_faulty <= w_faulty_nxt;
      r_degraded    <= |w_faulty_nxt;
    end
  end

  assign voted_o             = r_voted;
  assign voted_valid_o       = r_voted_valid;
  assign uncorrectable_o     = r_uncorr;
  assign lane_faulty_o       = r_lane_faulty;
  assign degraded_o          = r_degraded;
  assign mismatch_cnt_a_o    = r_mis_cnt[0];
  assign mismatch_cnt_b_o    = r_mis_cnt[1];
  assign mismatch_cnt_c_o    = r_mis_cnt[2];
  assign uncorrectable_cnt_o = r_unc_cnt;

endmodule
